// File: rtl/tetris_bag_generator.sv
// Tetris 7-bag piece generator: LFSR-driven bag draws feeding a current+preview queue with a hold slot.
// Latency: one draw per clock while filling; cur_valid rises PREVIEW_DEPTH+1 clocks after reset release and drops for one clock per pop.
// Backpressure: none; next_req/hold_req are honoured only while cur_valid is high and are dropped, not queued, otherwise.
//
// Ports:
//   clk            rising-edge system clock
//   rst            asynchronous active-low reset
//   seed_load      load seed_in into the LFSR (zero is replaced by SEED)
//   seed_in        new LFSR seed
//   next_req       consume the current piece
//   hold_req       move the current piece to hold, or swap it with the held piece
//   cur_piece      current piece index
//   cur_valid      cur_piece / preview valid (high only in READY)
//   preview        upcoming pieces, entry 0 in bits [PW-1:0]
//   hold_piece     held piece index
//   hold_valid     hold slot occupied
//   bag_remaining  pieces still undrawn in the current bag
module tetris_bag_generator #(
  parameter int NUM_PIECES    = 7,
  parameter int PREVIEW_DEPTH = 3,
  parameter int LFSR_WIDTH    = 16,
  parameter logic [LFSR_WIDTH-1:0] TAPS = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] SEED = 16'hACE1,
  localparam int PW = (NUM_PIECES > 2) ? $clog2(NUM_PIECES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        seed_load,
  input  logic [LFSR_WIDTH-1:0]       seed_in,
  input  logic                        next_req,
  input  logic                        hold_req,
  output logic [PW-1:0]               cur_piece,
  output logic                        cur_valid,
  output logic [PREVIEW_DEPTH*PW-1:0] preview,
  output logic [PW-1:0]               hold_piece,
  output logic                        hold_valid,
  output logic [3:0]                  bag_remaining
);

  localparam int QD = PREVIEW_DEPTH + 1;   // queue entries: head + preview
  localparam int CW = $clog2(QD + 1);      // occupancy counter width
  localparam int CE = 1 << PW;             // number of encodable candidates

  typedef enum logic {
    S_FILL,
    S_READY
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  logic [LFSR_WIDTH-1:0]   r_lfsr;
  logic [NUM_PIECES-1:0]   r_bag;
  logic [PW-1:0]           r_q [QD];
  logic [CW-1:0]           r_cnt;
  logic [PW-1:0]           r_hold;
  logic                    r_hold_vld;
  logic                    r_hold_used;

  // Registered output copies; refreshed only when the next state is READY so
  // that they stay frozen through FILL.
  logic [PW-1:0]               r_cur_piece;
  logic [PREVIEW_DEPTH*PW-1:0] r_preview;
  logic [PW-1:0]               r_hold_piece;
  logic                        r_hold_valid;
  logic [3:0]                  r_bag_rem;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  state_t                      w_state_nxt;
  logic [LFSR_WIDTH-1:0]       w_lfsr_step;
  logic [NUM_PIECES-1:0]       w_bag_nxt;
  logic [PW-1:0]               w_q_nxt [QD];
  logic [CW-1:0]               w_cnt_nxt;
  logic [PW-1:0]               w_hold_nxt;
  logic                        w_hold_vld_nxt;
  logic                        w_hold_used_nxt;
  logic [PREVIEW_DEPTH*PW-1:0] w_preview_nxt;

  // Draw path
  logic [CE-1:0]         w_bag_ext;
  logic [PW-1:0]         w_cand;
  logic                  w_cand_ok;
  logic [PW-1:0]         w_low;
  logic [PW-1:0]         w_draw;
  logic [NUM_PIECES-1:0] w_bag_clr;
  logic [NUM_PIECES-1:0] w_bag_after;

  function automatic logic [3:0] f_popcnt(input logic [NUM_PIECES-1:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_PIECES; i++) begin
      n = n + {3'b000, b[i]};
    end
    return n;
  endfunction

  // Galois step: shift right, fold the tap mask in when the bit shifted out is 1.
  assign w_lfsr_step = {1'b0, r_lfsr[LFSR_WIDTH-1:1]} ^ (r_lfsr[0] ? TAPS : '0);

  // Bag mask widened to every encodable candidate; candidates at or above
  // NUM_PIECES read as "not available" and fall back to the lowest set bit.
  for (genvar gi = 0; gi < CE; gi++) begin : g_bag_ext
    if (gi < NUM_PIECES) begin : g_in
      assign w_bag_ext[gi] = r_bag[gi];
    end else begin : g_out
      assign w_bag_ext[gi] = 1'b0;
    end
  end

  assign w_cand    = r_lfsr[PW-1:0];
  assign w_cand_ok = w_bag_ext[w_cand];

  always_comb begin
    w_low = '0;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (r_bag[i]) w_low = PW'(i);
    end
  end

  assign w_draw      = w_cand_ok ? w_cand : w_low;
  assign w_bag_clr   = r_bag & ~(NUM_PIECES'(1) << w_draw);
  // Last piece of a bag drawn: start the next bag on the same edge, so the
  // mask is never observed empty.
  assign w_bag_after = (w_bag_clr == '0) ? '1 : w_bag_clr;

  // ---------------------------------------------------------------------------
  // FSM next state and queue / hold updates
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_q_nxt         = r_q;
    w_cnt_nxt       = r_cnt;
    w_bag_nxt       = r_bag;
    w_hold_nxt      = r_hold;
    w_hold_vld_nxt  = r_hold_vld;
    w_hold_used_nxt = r_hold_used;

    case (r_state)
      S_FILL: begin
        // Exactly one draw appended at the tail per cycle.
        for (int i = 0; i < QD; i++) begin
          if (r_cnt == CW'(i)) w_q_nxt[i] = w_draw;
        end
        w_cnt_nxt = r_cnt + CW'(1);
        w_bag_nxt = w_bag_after;
        if (r_cnt == CW'(QD - 1)) w_state_nxt = S_READY;
      end

      S_READY: begin
        if (next_req) begin
          // Pop wins over hold when both arrive together.
          for (int i = 0; i < QD - 1; i++) begin
            w_q_nxt[i] = r_q[i+1];
          end
          w_q_nxt[QD-1]   = '0;
          w_cnt_nxt       = CW'(QD - 1);
          w_hold_used_nxt = 1'b0;
          w_state_nxt     = S_FILL;
        end else if (hold_req && !r_hold_used) begin
          w_hold_nxt      = r_q[0];
          w_hold_used_nxt = 1'b1;
          if (!r_hold_vld) begin
            // Empty slot: head leaves the queue, which must be refilled.
            for (int i = 0; i < QD - 1; i++) begin
              w_q_nxt[i] = r_q[i+1];
            end
            w_q_nxt[QD-1]  = '0;
            w_cnt_nxt      = CW'(QD - 1);
            w_hold_vld_nxt = 1'b1;
            w_state_nxt    = S_FILL;
          end else begin
            // Occupied slot: plain swap, queue stays full.
            w_q_nxt[0] = r_hold;
          end
        end
      end

      default: w_state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    w_preview_nxt = '0;
    for (int i = 0; i < PREVIEW_DEPTH; i++) begin
      w_preview_nxt[i*PW +: PW] = w_q_nxt[i+1];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_FILL;
      r_lfsr       <= SEED;
      r_bag        <= '1;
      for (int i = 0; i < QD; i++) begin
        r_q[i] <= '0;
      end
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hold_vld   <= 1'b0;
      r_hold_used  <= 1'b0;
      r_cur_piece  <= '0;
      r_preview    <= '0;
      r_hold_piece <= '0;
      r_hold_valid <= 1'b0;
      r_bag_rem    <= 4'(NUM_PIECES);
    end else begin
      // A seed load only redirects the random stream; queue, bag and hold
      // contents are left alone.
      if (seed_load) begin
        r_lfsr <= (seed_in == '0) ? SEED : seed_in;
      end else begin
        r_lfsr <= w_lfsr_step;
      end

      r_state     <= w_state_nxt;
      r_bag       <= w_bag_nxt;
      r_q         <= w_q_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_vld  <= w_hold_vld_nxt;
      r_hold_used <= w_hold_used_nxt;

      if (w_state_nxt == S_READY) begin
        r_cur_piece  <= w_q_nxt[0];
        r_preview    <= w_preview_nxt;
        r_hold_piece <= w_hold_nxt;
        r_hold_valid <= w_hold_vld_nxt;
        r_bag_rem    <= f_popcnt(w_bag_nxt);
      end
    end
  end

  assign cur_valid     = (r_state == S_READY);
  assign cur_piece     = r_cur_piece;
  assign preview       = r_preview;
  assign hold_piece    = r_hold_piece;
  assign hold_valid    = r_hold_valid;
  assign bag_remaining = r_bag_rem;

endmodule

// File: tb/tb_tetris_bag_generator.sv
// Directed bench for tetris_bag_generator: reset values, fill latency, bag permutations,
// hold/swap rules, request priority, async reset abort, seed load, and a 5-piece / depth-1 build.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tetris_bag_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst, seed_load, next_req, hold_req;
  logic [15:0] seed_in;
  logic [2:0]  cur_piece, hold_piece;
  logic        cur_valid, hold_valid;
  logic [8:0]  preview;
  logic [3:0]  bag_remaining;

  // NUM_PIECES=5, PREVIEW_DEPTH=1 instance
  logic        rst_b, next_req_b;
  logic [2:0]  cur_piece_b, hold_piece_b, preview_b;
  logic        cur_valid_b, hold_valid_b;
  logic [3:0]  bag_remaining_b;

  int n_chk  = 0;
  int n_fail = 0;

  tetris_bag_generator dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .next_req(next_req), .hold_req(hold_req),
    .cur_piece(cur_piece), .cur_valid(cur_valid), .preview(preview),
    .hold_piece(hold_piece), .hold_valid(hold_valid), .bag_remaining(bag_remaining)
  );

  tetris_bag_generator #(.NUM_PIECES(5), .PREVIEW_DEPTH(1)) dut_b (
    .clk(clk), .rst(rst_b), .seed_load(1'b0), .seed_in(16'h0000),
    .next_req(next_req_b), .hold_req(1'b0),
    .cur_piece(cur_piece_b), .cur_valid(cur_valid_b), .preview(preview_b),
    .hold_piece(hold_piece_b), .hold_valid(hold_valid_b), .bag_remaining(bag_remaining_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_cur_valid"},  32'(cur_valid),     32'd0);
    chk({tag, "_cur_piece"},  32'(cur_piece),     32'd0);
    chk({tag, "_preview"},    32'(preview),       32'd0);
    chk({tag, "_hold_piece"}, 32'(hold_piece),    32'd0);
    chk({tag, "_hold_valid"}, 32'(hold_valid),    32'd0);
    chk({tag, "_bag_rem"},    32'(bag_remaining), 32'd7);
  endtask

  // Release reset on a falling edge and count rising edges until cur_valid.
  // From SEED=ACE1 the draws are 1,0,2,4, leaving {3,5,6} in the bag.
  task automatic release_a(input string tag);
    int k;
    k = 0;
    rst = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!cur_valid && k < 20);
    chk({tag, "_rise_edges"}, 32'(k),             32'd4);
    chk({tag, "_first_cur"},  32'(cur_piece),     32'd1);
    chk({tag, "_first_prev"}, 32'(preview),       32'h110);
    chk({tag, "_first_bag"},  32'(bag_remaining), 32'd3);
    chk({tag, "_first_hold"}, 32'(hold_valid),    32'd0);
  endtask

  // One next_req pulse from READY; cur_valid must be low for exactly one sample.
  task automatic pop_a(output logic [2:0] piece);
    piece = cur_piece;
    next_req = 1'b1;
    @(negedge clk);
    next_req = 1'b0;
    chk("pop_valid_low", 32'(cur_valid), 32'd0);
    @(negedge clk);
    chk("pop_valid_back", 32'(cur_valid), 32'd1);
  endtask

  task automatic pop_b(output logic [2:0] piece);
    piece = cur_piece_b;
    next_req_b = 1'b1;
    @(negedge clk);
    next_req_b = 1'b0;
    chk("b_pop_valid_low", 32'(cur_valid_b), 32'd0);
    @(negedge clk);
    chk("b_pop_valid_back", 32'(cur_valid_b), 32'd1);
  endtask

  // Seed, then 10 pops. After the fixed post-reset queue 1,0,2,4 the draws
  // from lfsr=ACE1 (one pop edge + one fill edge per pop) are 3,5,6,1,2,0.
  task automatic seed_run(input string tag, input int idle, input logic [15:0] s);
    logic [2:0] exp_seq [10];
    logic [2:0] p;
    exp_seq = '{3'd1, 3'd0, 3'd2, 3'd4, 3'd3, 3'd5, 3'd6, 3'd1, 3'd2, 3'd0};
    rst = 1'b0;
    @(negedge clk);
    release_a(tag);
    repeat (idle) @(negedge clk);
    seed_in   = s;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pop_a(p);
      chk($sformatf("%s_seq%0d", tag, i), 32'(p), 32'(exp_seq[i]));
    end
  endtask

  initial begin
    logic [2:0] p, h0, p0, h1, h2, p2;
    logic [8:0] pv;
    logic [7:0] mask;

    rst = 1'b0; seed_load = 1'b0; seed_in = '0; next_req = 1'b0; hold_req = 1'b0;
    rst_b = 1'b0; next_req_b = 1'b0;
    repeat (2) @(negedge clk);

    chk_reset_a("reset");
    chk("b_reset_bag_rem", 32'(bag_remaining_b), 32'd5);
    chk("b_reset_valid",   32'(cur_valid_b),     32'd0);

    release_a("init");

    // 70 pops: every aligned group of 7 is a permutation of 0..6.
    for (int g = 0; g < 10; g++) begin
      mask = '0;
      for (int j = 0; j < 7; j++) begin
        pop_a(p);
        if (p < 3'd7) mask[p] = 1'b1;
      end
      chk($sformatf("perm7_group%0d", g), 32'(mask), 32'h7F);
    end

    // Hold into empty slot: head moves to hold, queue refills for one cycle.
    h0 = cur_piece;
    p0 = preview[2:0];
    hold_req = 1'b1;
    @(negedge clk);
    hold_req = 1'b0;
    chk("hold_empty_fill", 32'(cur_valid), 32'd0);
    @(negedge clk);
    chk("hold_empty_ready", 32'(cur_valid),  32'd1);
    chk("hold_empty_vld",   32'(hold_valid), 32'd1);
    chk("hold_empty_piece", 32'(hold_piece), 32'(h0));
    chk("hold_empty_cur",   32'(cur_piece),  32'(p0));

    // Second hold before any pop is ignored.
    hold_req = 1'b1;
    @(negedge clk);
    hold_req = 1'b0;
    chk("hold_again_valid", 32'(cur_valid),  32'd1);
    chk("hold_again_cur",   32'(cur_piece),  32'(p0));
    chk("hold_again_hold",  32'(hold_piece), 32'(h0));

    // Pop re-arms hold; the next hold is a swap that stays in READY.
    pop_a(p);
    chk("hold_pop_piece", 32'(p), 32'(p0));
    h1 = cur_piece;
    pv = preview;
    hold_req = 1'b1;
    @(negedge clk);
    hold_req = 1'b0;
    chk("swap_valid",   32'(cur_valid),  32'd1);
    chk("swap_cur",     32'(cur_piece),  32'(h0));
    chk("swap_hold",    32'(hold_piece), 32'(h1));
    chk("swap_preview", 32'(preview),    32'(pv));

    // Simultaneous next_req + hold_req with hold armed: pop only.
    pop_a(p);
    chk("pre_simul_pop", 32'(p), 32'(h0));
    h2 = cur_piece;
    p2 = preview[2:0];
    next_req = 1'b1;
    hold_req = 1'b1;
    @(negedge clk);
    next_req = 1'b0;
    hold_req = 1'b0;
    chk("simul_fill", 32'(cur_valid), 32'd0);
    @(negedge clk);
    chk("simul_ready", 32'(cur_valid),  32'd1);
    chk("simul_cur",   32'(cur_piece),  32'(p2));
    chk("simul_hold",  32'(hold_piece), 32'(h1));
    chk("simul_hvld",  32'(hold_valid), 32'd1);

    // A request still held high during the FILL cycle is not acted on.
    p2 = preview[2:0];
    next_req = 1'b1;
    @(negedge clk);
    chk("fill_req_low", 32'(cur_valid), 32'd0);
    @(negedge clk);
    next_req = 1'b0;
    chk("fill_req_ready", 32'(cur_valid), 32'd1);
    chk("fill_req_cur",   32'(cur_piece), 32'(p2));
    @(negedge clk);
    chk("fill_req_stay",  32'(cur_valid), 32'd1);

    // Reset pulled mid-FILL: outputs drop before any further clock edge.
    next_req = 1'b1;
    @(negedge clk);
    next_req = 1'b0;
    chk("midfill_in_fill", 32'(cur_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk_reset_a("midfill_rst");
    @(negedge clk);
    release_a("after_midfill");

    // Seed runs: seed_in=0 must behave as SEED; same seed, same sequence,
    // regardless of how long the LFSR free-ran beforehand.
    seed_run("seed_zero", 2, 16'h0000);
    seed_run("seed_ace1", 5, 16'hACE1);

    // 5-piece, depth-1 instance: ACE1 draws 1 then 0; READY after 2 edges.
    begin
      int k;
      k = 0;
      rst_b = 1'b1;
      do begin
        @(negedge clk);
        k++;
      end while (!cur_valid_b && k < 20);
      chk("b_rise_edges", 32'(k),               32'd2);
      chk("b_first_cur",  32'(cur_piece_b),     32'd1);
      chk("b_first_prev", 32'(preview_b),       32'd0);
      chk("b_first_bag",  32'(bag_remaining_b), 32'd3);
    end
    for (int g = 0; g < 4; g++) begin
      mask = '0;
      for (int j = 0; j < 5; j++) begin
        pop_b(p);
        chk("b_range", 32'(p < 3'd5), 32'd1);
        if (p < 3'd5) mask[p] = 1'b1;
      end
      chk($sformatf("b_perm5_group%0d", g), 32'(mask), 32'h1F);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

endmodule
